// File: rtl/nasti_burst_splitter_rd.sv
// -----------------------------------------------------------------------------
// nasti_burst_splitter_rd
//
// Purpose: read-path stage for slaves that cannot burst. Each upstream AR burst
// is accepted once, then issued downstream as a sequence of single-beat ARs
// (len=0). The returned beats are forwarded upstream as one rebuilt burst.
// At most one downstream request is outstanding at any time.
//
// Optional feature macro: NASTI_SPLIT_WRAP_EN
//   defined   -> WRAP bursts wrap inside an aligned (len+1)<<size byte window
//   undefined -> WRAP bursts are addressed like INCR (no wrap logic built)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   us_ar_*                  upstream AR channel (slave side of this block)
//   us_r_*                   upstream R channel (rebuilt burst)
//   ds_ar_*                  downstream AR channel (single-beat requests)
//   ds_r_*                   downstream R channel (one beat per request)
// -----------------------------------------------------------------------------
module nasti_burst_splitter_rd #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   us_ar_id,
  input  logic [ADDR_WIDTH-1:0] us_ar_addr,
  input  logic [7:0]            us_ar_len,
  input  logic [2:0]            us_ar_size,
  input  logic [1:0]            us_ar_burst,
  input  logic                  us_ar_lock,
  input  logic [3:0]            us_ar_cache,
  input  logic [2:0]            us_ar_prot,
  input  logic [3:0]            us_ar_qos,
  input  logic [3:0]            us_ar_region,
  input  logic [USER_WIDTH-1:0] us_ar_user,
  input  logic                  us_ar_valid,
  output logic                  us_ar_ready,
  output logic [ID_WIDTH-1:0]   us_r_id,
  output logic [DATA_WIDTH-1:0] us_r_data,
  output logic [1:0]            us_r_resp,
  output logic                  us_r_last,
  output logic [USER_WIDTH-1:0] us_r_user,
  output logic                  us_r_valid,
  input  logic                  us_r_ready,
  output logic [ID_WIDTH-1:0]   ds_ar_id,
  output logic [ADDR_WIDTH-1:0] ds_ar_addr,
  output logic [7:0]            ds_ar_len,
  output logic [2:0]            ds_ar_size,
  output logic [1:0]            ds_ar_burst,
  output logic                  ds_ar_lock,
  output logic [3:0]            ds_ar_cache,
  output logic [2:0]            ds_ar_prot,
  output logic [3:0]            ds_ar_qos,
  output logic [3:0]            ds_ar_region,
  output logic [USER_WIDTH-1:0] ds_ar_user,
  output logic                  ds_ar_valid,
  input  logic                  ds_ar_ready,
  input  logic [ID_WIDTH-1:0]   ds_r_id,
  input  logic [DATA_WIDTH-1:0] ds_r_data,
  input  logic [1:0]            ds_r_resp,
  input  logic                  ds_r_last,
  input  logic [USER_WIDTH-1:0] ds_r_user,
  input  logic                  ds_r_valid,
  output logic                  ds_r_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                r_state, w_state_next;
  logic [7:0]            r_cnt, w_cnt_next;

  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_lock;
  logic [3:0]            r_cache;
  logic [2:0]            r_prot;
  logic [3:0]            r_qos;
  logic [3:0]            r_region;
  logic [USER_WIDTH-1:0] r_user;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_last_beat;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_beat_addr;

  // Downstream beats always carry the captured id upstream, and the burst end
  // is decided by our own beat counter, so these downstream fields are unused.
  logic                  w_unused;
  assign w_unused = &{1'b0, ds_r_id, ds_r_last};

  assign w_ar_hs     = (r_state == S_IDLE) && us_ar_valid;
  assign w_r_hs      = (r_state == S_DATA) && ds_r_valid && us_r_ready;
  assign w_last_beat = (r_cnt == r_len);

  // ---------------------------------------------------------------------------
  // State and captured request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= 8'd0;
      r_size   <= 3'd0;
      r_burst  <= 2'd0;
      r_lock   <= 1'b0;
      r_cache  <= 4'd0;
      r_prot   <= 3'd0;
      r_qos    <= 4'd0;
      r_region <= 4'd0;
      r_user   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_ar_hs) begin
        r_id     <= us_ar_id;
        r_addr   <= us_ar_addr;
        r_len    <= us_ar_len;
        r_size   <= us_ar_size;
        r_burst  <= us_ar_burst;
        r_lock   <= us_ar_lock;
        r_cache  <= us_ar_cache;
        r_prot   <= us_ar_prot;
        r_qos    <= us_ar_qos;
        r_region <= us_ar_region;
        r_user   <= us_ar_user;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_ar_hs) begin
          w_state_next = S_ADDR;
          w_cnt_next   = 8'd0;
        end
      end
      S_ADDR: begin
        if (ds_ar_ready) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_r_hs) begin
          if (w_last_beat) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_ADDR;
            w_cnt_next   = r_cnt + 8'd1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat address. Derived only from registers, so it holds steady while a
  // downstream request is stalled.
  // ---------------------------------------------------------------------------
  assign w_offset = ADDR_WIDTH'(r_cnt) << r_size;

`ifdef NASTI_SPLIT_WRAP_EN
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  // Window is (len+1)<<size bytes; the mask selects the in-window offset bits.
  assign w_wrap_mask = (ADDR_WIDTH'({1'b0, r_len} + 9'd1) << r_size) - ADDR_WIDTH'(1);
`endif

  always_comb begin
    w_beat_addr = r_addr + w_offset;
    case (r_burst)
      2'b00: w_beat_addr = r_addr;
`ifdef NASTI_SPLIT_WRAP_EN
      2'b10: w_beat_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_offset) & w_wrap_mask);
`endif
      default: w_beat_addr = r_addr + w_offset;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign us_ar_ready  = (r_state == S_IDLE);

  assign ds_ar_valid  = (r_state == S_ADDR);
  assign ds_ar_id     = r_id;
  assign ds_ar_addr   = w_beat_addr;
  assign ds_ar_len    = 8'd0;
  assign ds_ar_size   = r_size;
  assign ds_ar_burst  = r_burst;
  assign ds_ar_lock   = r_lock;
  assign ds_ar_cache  = r_cache;
  assign ds_ar_prot   = r_prot;
  assign ds_ar_qos    = r_qos;
  assign ds_ar_region = r_region;
  assign ds_ar_user   = r_user;

  assign us_r_valid   = (r_state == S_DATA) && ds_r_valid;
  assign ds_r_ready   = (r_state == S_DATA) && us_r_ready;
  assign us_r_id      = r_id;
  assign us_r_data    = ds_r_data;
  assign us_r_resp    = ds_r_resp;
  assign us_r_user    = ds_r_user;
  assign us_r_last    = (r_state == S_DATA) && w_last_beat;

endmodule

// File: tb/tb_nasti_burst_splitter_rd.sv
// -----------------------------------------------------------------------------
// tb_nasti_burst_splitter_rd
//
// Directed bench for nasti_burst_splitter_rd (ID_WIDTH=4, ADDR_WIDTH=8,
// DATA_WIDTH=64, USER_WIDTH=1). Inputs are driven and outputs sampled on the
// falling edge (plus #1 for combinational R-path checks). Expected downstream
// addresses are hand-computed constants loaded into exp_addr per scenario.
// -----------------------------------------------------------------------------
module tb_nasti_burst_splitter_rd;

  localparam int IDW = 4;
  localparam int AW  = 8;
  localparam int DW  = 64;
  localparam int UW  = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [IDW-1:0] us_ar_id;
  logic [AW-1:0]  us_ar_addr;
  logic [7:0]     us_ar_len;
  logic [2:0]     us_ar_size;
  logic [1:0]     us_ar_burst;
  logic           us_ar_lock;
  logic [3:0]     us_ar_cache;
  logic [2:0]     us_ar_prot;
  logic [3:0]     us_ar_qos;
  logic [3:0]     us_ar_region;
  logic [UW-1:0]  us_ar_user;
  logic           us_ar_valid;
  logic           us_ar_ready;
  logic [IDW-1:0] us_r_id;
  logic [DW-1:0]  us_r_data;
  logic [1:0]     us_r_resp;
  logic           us_r_last;
  logic [UW-1:0]  us_r_user;
  logic           us_r_valid;
  logic           us_r_ready;
  logic [IDW-1:0] ds_ar_id;
  logic [AW-1:0]  ds_ar_addr;
  logic [7:0]     ds_ar_len;
  logic [2:0]     ds_ar_size;
  logic [1:0]     ds_ar_burst;
  logic           ds_ar_lock;
  logic [3:0]     ds_ar_cache;
  logic [2:0]     ds_ar_prot;
  logic [3:0]     ds_ar_qos;
  logic [3:0]     ds_ar_region;
  logic [UW-1:0]  ds_ar_user;
  logic           ds_ar_valid;
  logic           ds_ar_ready;
  logic [IDW-1:0] ds_r_id;
  logic [DW-1:0]  ds_r_data;
  logic [1:0]     ds_r_resp;
  logic           ds_r_last;
  logic [UW-1:0]  ds_r_user;
  logic           ds_r_valid;
  logic           ds_r_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_addr [0:15];

  always #5 clk = ~clk;

  nasti_burst_splitter_rd #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst(rst),
    .us_ar_id(us_ar_id), .us_ar_addr(us_ar_addr), .us_ar_len(us_ar_len),
    .us_ar_size(us_ar_size), .us_ar_burst(us_ar_burst), .us_ar_lock(us_ar_lock),
    .us_ar_cache(us_ar_cache), .us_ar_prot(us_ar_prot), .us_ar_qos(us_ar_qos),
    .us_ar_region(us_ar_region), .us_ar_user(us_ar_user),
    .us_ar_valid(us_ar_valid), .us_ar_ready(us_ar_ready),
    .us_r_id(us_r_id), .us_r_data(us_r_data), .us_r_resp(us_r_resp),
    .us_r_last(us_r_last), .us_r_user(us_r_user),
    .us_r_valid(us_r_valid), .us_r_ready(us_r_ready),
    .ds_ar_id(ds_ar_id), .ds_ar_addr(ds_ar_addr), .ds_ar_len(ds_ar_len),
    .ds_ar_size(ds_ar_size), .ds_ar_burst(ds_ar_burst), .ds_ar_lock(ds_ar_lock),
    .ds_ar_cache(ds_ar_cache), .ds_ar_prot(ds_ar_prot), .ds_ar_qos(ds_ar_qos),
    .ds_ar_region(ds_ar_region), .ds_ar_user(ds_ar_user),
    .ds_ar_valid(ds_ar_valid), .ds_ar_ready(ds_ar_ready),
    .ds_r_id(ds_r_id), .ds_r_data(ds_r_data), .ds_r_resp(ds_r_resp),
    .ds_r_last(ds_r_last), .ds_r_user(ds_r_user),
    .ds_r_valid(ds_r_valid), .ds_r_ready(ds_r_ready)
  );

  // Present an AR for one cycle from a falling edge; returns on the next
  // falling edge, where ds_ar_valid must already be high (1-cycle latency).
  task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    n_cmp++;
    if (us_ar_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ar_ready_idle: got %b want 1", us_ar_ready);
    end
    us_ar_valid = 1'b1; us_ar_id = id; us_ar_addr = addr; us_ar_len = len;
    us_ar_size = size; us_ar_burst = burst; us_ar_lock = 1'b1;
    us_ar_cache = 4'hA; us_ar_prot = 3'h5; us_ar_qos = 4'h6;
    us_ar_region = 4'h9; us_ar_user = 1'b1;
    @(negedge clk);
    us_ar_valid = 1'b0;
    n_cmp++;
    if (ds_ar_valid !== 1'b1 || ds_ar_cache !== 4'hA || ds_ar_prot !== 3'h5 ||
        ds_ar_qos !== 4'h6 || ds_ar_region !== 4'h9 || ds_ar_lock !== 1'b1 ||
        ds_ar_user !== 1'b1 || ds_ar_size !== size || ds_ar_burst !== burst) begin
      n_err++;
      $display("FAIL ar_first_issue: valid=%b cache=%h prot=%h qos=%h region=%h size=%0d burst=%0d want valid=1 cache=a prot=5 qos=6 region=9 size=%0d burst=%0d",
               ds_ar_valid, ds_ar_cache, ds_ar_prot, ds_ar_qos, ds_ar_region,
               ds_ar_size, ds_ar_burst, size, burst);
    end
  endtask

  // Called on a falling edge with ds_ar_valid high for beat b. Accepts the
  // downstream AR, then returns one R beat (with one cycle of upstream stall).
  task automatic serve_beat(input int b, input logic [7:0] len,
                            input logic [IDW-1:0] id, input logic [1:0] resp);
    logic [DW-1:0] data;
    n_cmp++;
    if (ds_ar_valid !== 1'b1 || ds_ar_addr !== exp_addr[b] || ds_ar_len !== 8'd0 ||
        ds_ar_id !== id) begin
      n_err++;
      $display("FAIL ds_ar_beat%0d: valid=%b addr=%h len=%0d id=%h want valid=1 addr=%h len=0 id=%h",
               b, ds_ar_valid, ds_ar_addr, ds_ar_len, ds_ar_id, exp_addr[b], id);
    end
    n_cmp++;
    if (us_ar_ready !== 1'b0 || us_r_valid !== 1'b0 || ds_r_ready !== 1'b0) begin
      n_err++;
      $display("FAIL addr_phase_gating%0d: ar_ready=%b r_valid=%b ds_r_ready=%b want 0 0 0",
               b, us_ar_ready, us_r_valid, ds_r_ready);
    end
    ds_ar_ready = 1'b1;
    @(negedge clk);
    ds_ar_ready = 1'b0;
    data = {$urandom, $urandom};
    ds_r_valid = 1'b1; ds_r_data = data; ds_r_resp = resp; ds_r_id = ~id;
    ds_r_user = b[0]; ds_r_last = (b != int'(len)); us_r_ready = 1'b0;
    #1;
    n_cmp++;
    if (ds_ar_valid !== 1'b0 || us_r_valid !== 1'b1 || ds_r_ready !== 1'b0) begin
      n_err++;
      $display("FAIL data_stall%0d: ds_ar_valid=%b us_r_valid=%b ds_r_ready=%b want 0 1 0",
               b, ds_ar_valid, us_r_valid, ds_r_ready);
    end
    @(negedge clk);
    us_r_ready = 1'b1;
    #1;
    n_cmp++;
    if (us_r_valid !== 1'b1 || ds_r_ready !== 1'b1 || us_r_data !== data ||
        us_r_resp !== resp || us_r_user !== b[0] || us_r_id !== id ||
        us_r_last !== (b == int'(len))) begin
      n_err++;
      $display("FAIL r_beat%0d: valid=%b ready=%b data=%h resp=%0d user=%b id=%h last=%b want 1 1 %h %0d %b %h %b",
               b, us_r_valid, ds_r_ready, us_r_data, us_r_resp, us_r_user, us_r_id,
               us_r_last, data, resp, b[0], id, (b == int'(len)));
    end
    @(negedge clk);
    ds_r_valid = 1'b0; us_r_ready = 1'b0; ds_r_last = 1'b0;
  endtask

  task automatic run_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int err_beat);
    send_ar(id, addr, len, size, burst);
    for (int b = 0; b <= int'(len); b++)
      serve_beat(b, len, id, (b == err_beat) ? 2'b10 : 2'b00);
    n_cmp++;
    if (us_ar_ready !== 1'b1 || ds_ar_valid !== 1'b0 || us_r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL burst_end: ar_ready=%b ds_ar_valid=%b us_r_valid=%b want 1 0 0",
               us_ar_ready, ds_ar_valid, us_r_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    us_ar_valid = 1'b0; us_ar_id = '0; us_ar_addr = '0; us_ar_len = '0;
    us_ar_size = '0; us_ar_burst = '0; us_ar_lock = 1'b0; us_ar_cache = '0;
    us_ar_prot = '0; us_ar_qos = '0; us_ar_region = '0; us_ar_user = '0;
    us_r_ready = 1'b0; ds_ar_ready = 1'b0; ds_r_valid = 1'b0; ds_r_id = '0;
    ds_r_data = '0; ds_r_resp = '0; ds_r_last = 1'b0; ds_r_user = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (us_ar_ready !== 1'b1 || ds_ar_valid !== 1'b0 || us_r_valid !== 1'b0 ||
        ds_r_ready !== 1'b0 || ds_ar_addr !== 8'h00 || ds_ar_id !== 4'h0) begin
      n_err++;
      $display("FAIL reset_state: ar_ready=%b ds_ar_valid=%b r_valid=%b ds_r_ready=%b addr=%h id=%h want 1 0 0 0 00 0",
               us_ar_ready, ds_ar_valid, us_r_valid, ds_r_ready, ds_ar_addr, ds_ar_id);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_incr();
    exp_addr[0] = 8'h10; exp_addr[1] = 8'h18; exp_addr[2] = 8'h20; exp_addr[3] = 8'h28;
    run_burst(4'h5, 8'h10, 8'd3, 3'd3, 2'b01, -1);
  endtask

  task automatic test_fixed();
    exp_addr[0] = 8'h40; exp_addr[1] = 8'h40; exp_addr[2] = 8'h40;
    run_burst(4'h9, 8'h40, 8'd2, 3'd3, 2'b00, -1);
  endtask

  task automatic test_stall();
    exp_addr[0] = 8'h80;
    send_ar(4'h3, 8'h80, 8'd0, 3'd2, 2'b01);
    // A competing upstream AR during the stall must not be taken.
    us_ar_valid = 1'b1; us_ar_addr = 8'hEE; us_ar_id = 4'hC;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (ds_ar_valid !== 1'b1 || ds_ar_addr !== 8'h80 || ds_ar_id !== 4'h3 ||
          ds_ar_size !== 3'd2 || us_ar_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: valid=%b addr=%h id=%h size=%0d ar_ready=%b want 1 80 3 2 0",
                 i, ds_ar_valid, ds_ar_addr, ds_ar_id, ds_ar_size, us_ar_ready);
      end
      @(negedge clk);
    end
    us_ar_valid = 1'b0;
    serve_beat(0, 8'd0, 4'h3, 2'b00);
    n_cmp++;
    if (us_ar_ready !== 1'b1 || ds_ar_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_len0_end: ar_ready=%b ds_ar_valid=%b want 1 0", us_ar_ready, ds_ar_valid);
    end
  endtask

  task automatic test_wrap();
`ifdef NASTI_SPLIT_WRAP_EN
    exp_addr[0] = 8'h38; exp_addr[1] = 8'h20; exp_addr[2] = 8'h28; exp_addr[3] = 8'h30;
`else
    exp_addr[0] = 8'h38; exp_addr[1] = 8'h40; exp_addr[2] = 8'h48; exp_addr[3] = 8'h50;
`endif
    run_burst(4'hA, 8'h38, 8'd3, 3'd3, 2'b10, -1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) exp_addr[i] = 8'(i * 8);
    send_ar(4'h6, 8'h00, 8'd7, 3'd3, 2'b01);
    serve_beat(0, 8'd7, 4'h6, 2'b00);
    serve_beat(1, 8'd7, 4'h6, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (ds_ar_valid !== 1'b0 || us_r_valid !== 1'b0 || us_ar_ready !== 1'b1 ||
        ds_r_ready !== 1'b0 || ds_ar_addr !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid: ds_ar_valid=%b r_valid=%b ar_ready=%b ds_r_ready=%b addr=%h want 0 0 1 0 00",
               ds_ar_valid, us_r_valid, us_ar_ready, ds_r_ready, ds_ar_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (ds_ar_valid !== 1'b0 || us_r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: ds_ar_valid=%b r_valid=%b want 0 0", ds_ar_valid, us_r_valid);
    end
    exp_addr[0] = 8'h22;
    run_burst(4'h2, 8'h22, 8'd0, 3'd0, 2'b01, -1);
  endtask

  task automatic test_err_wrap_addr();
    exp_addr[0] = 8'hF8; exp_addr[1] = 8'h00;
    run_burst(4'hF, 8'hF8, 8'd1, 3'd3, 2'b01, 1);
  endtask

  task automatic test_back_to_back();
    exp_addr[0] = 8'h05; exp_addr[1] = 8'h06;
    run_burst(4'h1, 8'h05, 8'd1, 3'd0, 2'b11, 0);
    exp_addr[0] = 8'h60; exp_addr[1] = 8'h62; exp_addr[2] = 8'h64;
    run_burst(4'h7, 8'h60, 8'd2, 3'd1, 2'b01, -1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_incr();
    test_fixed();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_err_wrap_addr();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
